// File: rtl/rv_muldiv_unit_if.sv
// rv_muldiv_unit_if: request/response bundle of the iterative mul/div unit.
// The pipeline side is master; the unit itself is the slave.
interface rv_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic [2:0]      FUNC;
    logic            kill;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] S;
    logic            busy;

    modport master (
        output in_valid, A, B, FUNC, kill, out_ready,
        input  in_ready, out_valid, S, busy
    );

    modport slave (
        input  in_valid, A, B, FUNC, kill, out_ready,
        output in_ready, out_valid, S, busy
    );
endinterface

// File: rtl/rv_muldiv_unit.sv
// rv_muldiv_unit: iterative RV32M multiply/divide, one radix-2 step per clock.
// Shift-add multiply and restoring divide share one 2*XLEN working register.
module rv_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input logic             clk,
    input logic             rst_n,
    rv_muldiv_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    localparam logic [XLEN-1:0] MIN_V = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        func_q;
    logic              neg_q;
    logic [2*XLEN-1:0] prod_q;
    logic [XLEN-1:0]   opb_q;
    logic [XLEN-1:0]   s_q;

    logic              sgn_a, sgn_b, neg_a, neg_b;
    logic              b_zero, ovf, special;
    logic [XLEN-1:0]   abs_a, abs_b, spec_v;

    logic [XLEN:0]     add_w, shl_w, sub_w;
    logic [XLEN-1:0]   hi_w, lo_w, rem_w, res_d;
    logic [2*XLEN-1:0] prod_d, full_w;

    // Operand magnitudes and early-out results for the accept cycle
    always_comb begin
        sgn_a   = bus.FUNC[2] ? !bus.FUNC[0] : (bus.FUNC[1:0] != 2'b11);
        sgn_b   = bus.FUNC[2] ? !bus.FUNC[0] : !bus.FUNC[1];
        neg_a   = sgn_a & bus.A[XLEN-1];
        neg_b   = sgn_b & bus.B[XLEN-1];
        abs_a   = neg_a ? -bus.A : bus.A;
        abs_b   = neg_b ? -bus.B : bus.B;
        b_zero  = (bus.B == '0);
        ovf     = !bus.FUNC[0] && (bus.A == MIN_V) && (bus.B == '1);
        special = bus.FUNC[2] && (b_zero || ovf);
        if (b_zero) begin
            spec_v = bus.FUNC[1] ? bus.A : '1;
        end else if (bus.FUNC[1]) begin
            spec_v = '0;
        end else begin
            spec_v = bus.A;
        end
    end

    // One iteration step and the final sign fix / half selection
    always_comb begin
        hi_w  = prod_q[2*XLEN-1:XLEN];
        lo_w  = prod_q[XLEN-1:0];
        add_w = {1'b0, hi_w} + (lo_w[0] ? {1'b0, opb_q} : '0);
        shl_w = {hi_w, lo_w[XLEN-1]};
        sub_w = shl_w - {1'b0, opb_q};
        if (func_q[2]) begin
            if (sub_w[XLEN]) begin
                prod_d = {shl_w[XLEN-1:0], lo_w[XLEN-2:0], 1'b0};
            end else begin
                prod_d = {sub_w[XLEN-1:0], lo_w[XLEN-2:0], 1'b1};
            end
        end else begin
            prod_d = {add_w, lo_w[XLEN-1:1]};
        end
        full_w = neg_q ? -prod_q : prod_q;
        rem_w  = neg_q ? -hi_w : hi_w;
        unique case (1'b1)
            !func_q[2] && (func_q[1:0] == 2'b00): res_d = full_w[XLEN-1:0];
            !func_q[2] && (func_q[1:0] != 2'b00): res_d = full_w[2*XLEN-1:XLEN];
            func_q[2] && !func_q[1]:              res_d = full_w[XLEN-1:0];
            default:                              res_d = rem_w;
        endcase
    end

    // Control FSM with the datapath registers it sequences
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            func_q  <= '0;
            neg_q   <= 1'b0;
            prod_q  <= '0;
            opb_q   <= '0;
            s_q     <= '0;
        end else if (bus.kill) begin
            state_q <= IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        func_q <= bus.FUNC;
                        neg_q  <= (bus.FUNC[2] && bus.FUNC[1]) ? neg_a
                                                               : (neg_a ^ neg_b);
                        prod_q <= {{XLEN{1'b0}}, abs_a};
                        opb_q  <= abs_b;
                        cnt_q  <= '0;
                        if (special) begin
                            s_q     <= spec_v;
                            state_q <= DONE;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    prod_q <= prod_d;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    s_q     <= res_d;
                    state_q <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.S         = s_q;

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// tb_rv_muldiv_unit: scoreboard bench for the mul/div unit at XLEN=32 and 8.
// Expected results come from spec constants or a native-arithmetic model.
module tb_rv_muldiv_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    logic [31:0] q32[$];
    string       t32[$];
    logic [31:0] q8[$];
    string       t8[$];

    rv_muldiv_unit_if #(.XLEN(32)) bus ();
    rv_muldiv_unit_if #(.XLEN(8))  bus8 ();

    rv_muldiv_unit #(.XLEN(32)) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    rv_muldiv_unit #(.XLEN(8)) u_dut8 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus8.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input int w, input logic [2:0] f,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] m, ua, ub, sa, sb, r;
        m  = (64'd1 << w) - 64'd1;
        ua = {32'd0, a} & m;
        ub = {32'd0, b} & m;
        sa = ua[w-1] ? (ua | ~m) : ua;
        sb = ub[w-1] ? (ub | ~m) : ub;
        case (f)
            3'd0:    r = sa * sb;
            3'd1:    r = (sa * sb) >> w;
            3'd2:    r = (sa * ub) >> w;
            3'd3:    r = (ua * ub) >> w;
            3'd4:    r = (ub == 0) ? '1 : 64'($signed(sa) / $signed(sb));
            3'd5:    r = (ub == 0) ? '1 : ua / ub;
            3'd6:    r = (ub == 0) ? ua : 64'($signed(sa) % $signed(sb));
            default: r = (ub == 0) ? ua : ua % ub;
        endcase
        r = r & m;
        return r[31:0];
    endfunction

    // Scoreboard pops on every consumed result
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready && !bus.kill) begin
            if (q32.size() == 0) begin
                check("spurious32", 1, 0);
            end else begin
                check(t32.pop_front(), bus.S, q32.pop_front());
            end
        end
        if (rst_n && bus8.out_valid && bus8.out_ready && !bus8.kill) begin
            if (q8.size() == 0) begin
                check("spurious8", 1, 0);
            end else begin
                check(t8.pop_front(), bus8.S, q8.pop_front());
            end
        end
    end

    task automatic issue(input bit n8, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string tag,
                         input bit push);
        int n = 0;
        if (n8) begin
            bus8.FUNC = f;
            bus8.A = a[7:0];
            bus8.B = b[7:0];
            bus8.in_valid = 1'b1;
        end else begin
            bus.FUNC = f;
            bus.A = a;
            bus.B = b;
            bus.in_valid = 1'b1;
        end
        @(negedge clk);
        while (!(n8 ? bus8.in_ready : bus.in_ready)) begin
            n++;
            if (n > 200) begin
                check({tag, "_accept_timeout"}, 0, 1);
                bus.in_valid = 1'b0;
                bus8.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        if (push && n8) begin
            q8.push_back(exp);
            t8.push_back(tag);
        end else if (push) begin
            q32.push_back(exp);
            t32.push_back(tag);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus8.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          seen;
        logic [2:0]  f;
        logic [31:0] a, b, s0;

        bus.in_valid = 0; bus.A = 0; bus.B = 0; bus.FUNC = 0;
        bus.kill = 0; bus.out_ready = 1;
        bus8.in_valid = 0; bus8.A = 0; bus8.B = 0; bus8.FUNC = 0;
        bus8.kill = 0; bus8.out_ready = 1;

        #12;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_S", bus.S, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(0, 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, "mul_7x-3", 1);
        wait_valid(lat);
        check("mul_latency", lat, 33);
        issue(0, 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, "mulh", 1);
        issue(0, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu", 1);
        issue(0, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu", 1);
        issue(0, 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "div_-7_2", 1);
        issue(0, 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "rem_-7_2", 1);
        issue(0, 3'd5, 32'hFFFFFFFF, 32'd16, 32'h0FFFFFFF, "divu_16", 1);
        issue(0, 3'd7, 32'hFFFFFFFF, 32'd16, 32'h0000000F, "remu_16", 1);
        wait_valid(lat);
        @(posedge clk);
        #1;
        issue(0, 3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, "divu_by0", 1);
        wait_valid(lat);
        check("divu_by0_latency", lat, 0);
        issue(0, 3'd6, 32'd5, 32'd0, 32'd5, "rem_by0", 1);
        wait_valid(lat);
        check("rem_by0_latency", lat, 0);
        issue(0, 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf", 1);
        issue(0, 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, "rem_ovf", 1);

        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            if (i % 4 == 1) b = $urandom_range(1, 20);
            if (i % 9 == 3) b = 0;
            issue(0, f, a, b, ref_op(32, f, a, b), "rnd32", 1);
        end

        // Consumer stall in DONE
        wait_valid(lat);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        issue(0, 3'd3, 32'h12345678, 32'h9ABCDEF0,
              ref_op(32, 3'd3, 32'h12345678, 32'h9ABCDEF0), "stall_mulhu", 1);
        wait_valid(lat);
        s0 = bus.S;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("stall_S", bus.S, s0);
            check("stall_out_valid", bus.out_valid, 1);
            check("stall_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_out_valid", bus.out_valid, 0);
        check("release_in_ready", bus.in_ready, 1);

        // Kill mid-CALC drops the result
        issue(0, 3'd4, 32'd1000, 32'd7, 32'd0, "killed", 0);
        repeat (10) @(posedge clk);
        #1;
        bus.kill = 1'b1;
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
        check("kill_busy", bus.busy, 0);
        check("kill_in_ready", bus.in_ready, 1);
        check("kill_out_valid", bus.out_valid, 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        check("kill_no_result", seen, 0);

        // Asynchronous reset mid-CALC
        issue(0, 3'd0, 32'd3, 32'd5, 32'd0, "reset_victim", 0);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_in_ready", bus.in_ready, 1);
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_S", bus.S, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // XLEN=8 regression
        issue(1, 3'd4, 32'h80, 32'hFF, 32'h80, "div8_ovf", 1);
        issue(1, 3'd3, 32'hFF, 32'hFF, 32'hFE, "mulhu8", 1);
        issue(1, 3'd0, 32'd7, 32'hFD, 32'hEB, "mul8", 1);
        for (int i = 0; i < 30; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            if (i % 7 == 2) b = 0;
            issue(1, f, a, b, ref_op(8, f, a, b), "rnd8", 1);
        end

        seen = 0;
        while ((q32.size() != 0 || q8.size() != 0) && seen < 200) begin
            @(posedge clk);
            seen++;
        end
        check("drain", q32.size() + q8.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
